mips_fetch_queue: RTL

MIPS_FETCH_QUEUE -- requirements
Module: mips_fetch_queue

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/mips_fetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
// Holds the fetch FSM state encoding and the queue entry layout.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] word_align(
        input logic [WORD_W-1:0] a
    );
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous queue of {pc, word} entries with a single-cycle flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  wr_ptr_d;
    logic [AW:0]  rd_ptr_q;
    logic [AW:0]  rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = (count != '0) ? mem_q[rd_ptr_q[AW-1:0]] : '0;

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction fetch unit: issues word reads and buffers returned
// instructions for decode, with redirect and credit-based flow control.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  fetch_pc_d;
    logic [31:0]  req_addr_q;
    logic [31:0]  req_addr_d;

    logic         req;
    logic         push;
    logic         pop;
    logic         credit;
    logic [AW:0]  count;
    logic [AW:0]  in_flight;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign in_flight = (state_q != IDLE) ? (AW+1)'(1) : '0;
    assign credit    = (count + in_flight) < DEPTH_C;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        req        = 1'b0;
        push       = 1'b0;
        imem_addr  = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (credit) begin
                    req        = 1'b1;
                    req_addr_d = fetch_pc_q;
                    if (redirect_valid) begin
                        state_d = imem_ack ? IDLE : DRAIN;
                    end else if (imem_ack) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_INC;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req       = 1'b1;
                imem_addr = req_addr_q;
                if (redirect_valid) begin
                    state_d = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                // Old address stays on the bus until the stale word returns.
                req       = 1'b1;
                imem_addr = req_addr_q;
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign imem_req   = req & rst_n;
    assign push_entry = '{pc: fetch_pc_q, word: imem_rdata};
    assign pop        = instr_valid & instr_ready & ~redirect_valid;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;

endmodule
